// File: rtl/setup_pkg.sv
// Shared definitions for the serial frame receiver: frame-state encoding and default width.
package setup_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned STATE_W       = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_DATA = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAR  = 2'd2;

endpackage

// File: rtl/setup_shift_core.sv
// Serial-to-parallel datapath: working shift register with selectable bit order
// and a running even-parity accumulator over the shifted bits.
module setup_shift_core
    import setup_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             shift,
    input  logic             start,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] next_word_c,
    output logic             parity
);

    logic [WIDTH-1:0] base_c;

    // A frame start discards whatever the previous frame left behind.
    always_comb begin
        base_c = start ? '0 : word;
        if (MSB_FIRST) begin
            next_word_c = {base_c[WIDTH-2:0], bit_in};
        end else begin
            next_word_c = {bit_in, base_c[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            word   <= '0;
            parity <= 1'b0;
        end else if (shift) begin
            word   <= next_word_c;
            parity <= (start ? 1'b0 : parity) ^ bit_in;
        end
    end

endmodule

// File: rtl/setup_frame_reg.sv
// Serial frame receiver: frame FSM, bit counter and commit of completed frames
// into a shadow register, with optional trailing even-parity check.
module setup_frame_reg
    import setup_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       en_in,
    input  logic                       serial_in,
    input  logic                       abort_in,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       valid_out,
    output logic                       parity_err_out,
    output logic                       busy_out,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               shift_c;
    logic               start_c;
    logic               clear_c;
    logic               commit_c;
    logic               err_c;
    logic [WIDTH-1:0]   commit_word_c;
    logic [WIDTH-1:0]   word;
    logic [WIDTH-1:0]   next_word_c;
    logic               parity;

    setup_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear       (clear_c),
        .shift       (shift_c),
        .start       (start_c),
        .bit_in      (serial_in),
        .word        (word),
        .next_word_c (next_word_c),
        .parity      (parity)
    );

    // Next-state, counter and commit decisions; abort wins over a valid bit.
    always_comb begin
        state_next    = state;
        cnt_next      = bit_cnt;
        shift_c       = 1'b0;
        start_c       = 1'b0;
        clear_c       = 1'b0;
        commit_c      = 1'b0;
        err_c         = 1'b0;
        commit_word_c = word;
        if (abort_in) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            clear_c    = 1'b1;
        end else if (en_in) begin
            case (state)
                ST_IDLE: begin
                    shift_c    = 1'b1;
                    start_c    = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = ST_DATA;
                end
                ST_DATA: begin
                    shift_c = 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        cnt_next = '0;
                        if (PARITY_EN) begin
                            state_next = ST_PAR;
                        end else begin
                            // Final bit is still in flight, so commit the shifter's next value.
                            commit_c      = 1'b1;
                            commit_word_c = next_word_c;
                            state_next    = ST_IDLE;
                        end
                    end else begin
                        cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
                ST_PAR: begin
                    state_next = ST_IDLE;
                    if (parity ^ serial_in) begin
                        err_c = 1'b1;
                    end else begin
                        commit_c = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            parallel_out   <= '0;
            valid_out      <= 1'b0;
            parity_err_out <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            state          <= state_next;
            bit_cnt        <= cnt_next;
            valid_out      <= commit_c;
            parity_err_out <= err_c;
            busy_out       <= (state_next != ST_IDLE);
            if (commit_c) begin
                parallel_out <= commit_word_c;
            end
        end
    end

    assign bit_cnt_out = bit_cnt;

endmodule

// File: tb/tb_setup_frame_reg.sv
// Scoreboard bench: three receiver variants (LSB-first, MSB-first, LSB-first with parity)
// share one stimulus stream and are checked against a bit-list reference model.
module tb_setup_frame_reg;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_in    = 1'b1;
    logic en_in     = 1'b0;
    logic serial_in = 1'b0;
    logic abort_in  = 1'b0;

    logic [2:0][W-1:0]  pout;
    logic [2:0][CW-1:0] cnt;
    logic [2:0]         vld;
    logic [2:0]         perr;
    logic [2:0]         bsy;

    setup_frame_reg #(.WIDTH(W), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
        .clk_in(clk), .rst_in(rst_in), .en_in(en_in), .serial_in(serial_in), .abort_in(abort_in),
        .parallel_out(pout[0]), .valid_out(vld[0]), .parity_err_out(perr[0]),
        .busy_out(bsy[0]), .bit_cnt_out(cnt[0]));

    setup_frame_reg #(.WIDTH(W), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
        .clk_in(clk), .rst_in(rst_in), .en_in(en_in), .serial_in(serial_in), .abort_in(abort_in),
        .parallel_out(pout[1]), .valid_out(vld[1]), .parity_err_out(perr[1]),
        .busy_out(bsy[1]), .bit_cnt_out(cnt[1]));

    setup_frame_reg #(.WIDTH(W), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_par (
        .clk_in(clk), .rst_in(rst_in), .en_in(en_in), .serial_in(serial_in), .abort_in(abort_in),
        .parallel_out(pout[2]), .valid_out(vld[2]), .parity_err_out(perr[2]),
        .busy_out(bsy[2]), .bit_cnt_out(cnt[2]));

    // Reference model state: bits received so far in the current frame, last committed word.
    logic [8:0]  fr_bits [3];
    int          fr_n    [3];
    logic [7:0]  last    [3];
    logic [10:0] exp_q[$];   // {instance, is_err, word}
    bit          armed = 1'b0;
    bit          done  = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [7:0] assemble(input logic [8:0] b, input bit msb);
        logic [7:0] w;
        for (int k = 0; k < 8; k++) begin
            if (msb) w[7-k] = b[k];
            else     w[k]   = b[k];
        end
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst_in) begin
                    fr_bits[i] = '0; fr_n[i] = 0; last[i] = '0;
                end else if (abort_in) begin
                    fr_bits[i] = '0; fr_n[i] = 0;
                end else if (en_in) begin
                    logic [7:0] w;
                    fr_bits[i][fr_n[i]] = serial_in;
                    fr_n[i]++;
                    w = assemble(fr_bits[i], i == 1);
                    if (i != 2 && fr_n[i] == 8) begin
                        last[i] = w;
                        exp_q.push_back({2'(i), 1'b0, w});
                        fr_bits[i] = '0; fr_n[i] = 0;
                    end else if (i == 2 && fr_n[i] == 9) begin
                        if (^fr_bits[i]) begin
                            exp_q.push_back({2'(i), 1'b1, last[i]});
                        end else begin
                            last[i] = w;
                            exp_q.push_back({2'(i), 1'b0, w});
                        end
                        fr_bits[i] = '0; fr_n[i] = 0;
                    end
                end
            end
            armed = 1'b1;
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", name, i, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle state checks plus scoreboard matching of every output pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < 3; i++) begin
                    check("busy", i, 32'(bsy[i]), 32'(fr_n[i] > 0));
                    check("bit_cnt", i, 32'(cnt[i]), (fr_n[i] < 8) ? 32'(fr_n[i]) : 32'd0);
                    check("parallel", i, 32'(pout[i]), 32'(last[i]));
                    if (vld[i] && perr[i]) begin
                        n_cmp++; n_bad++;
                        $display("FAIL both_pulses inst%0d @%0t: valid=1 parity_err=1, expected at most one", i, $time);
                    end
                    if (vld[i] || perr[i]) begin
                        int found;
                        found = -1;
                        for (int j = 0; j < exp_q.size(); j++) begin
                            if (exp_q[j][10:9] == 2'(i)) begin
                                found = j;
                                break;
                            end
                        end
                        if (found < 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected_pulse inst%0d @%0t: valid=%0b parity_err=%0b, expected none",
                                     i, $time, vld[i], perr[i]);
                        end else begin
                            logic [10:0] e;
                            e = exp_q[found];
                            exp_q.delete(found);
                            check("pulse_kind", i, 32'(perr[i]), 32'(e[8]));
                            check("pulse_word", i, 32'(pout[i]), 32'(e[7:0]));
                        end
                    end
                end
                while (exp_q.size() > 0) begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL missing_pulse inst%0d @%0t: got no pulse, expected err=%0b word=%0h",
                             e[10:9], $time, e[8], e[7:0]);
                end
            end
            if (done) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    task automatic drive(input logic e, input logic s, input logic a, input logic r);
        en_in = e; serial_in = s; abort_in = a; rst_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [8:0] v, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, v[k], 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // 0,1,0,1,... -> 0xAA LSB-first, 0x55 MSB-first
        send_bits(9'h0AA, 8);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // 1,1,1,1,0,0,0,0 -> 0xF0 MSB-first
        send_bits(9'h00F, 8);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        // parity frames: 0x0F/par 0 commits, 0x07/par 0 fails
        send_bits(9'h00F, 9);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(9'h007, 9);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        // 0x3C with a 3-cycle pause after bit 4
        for (int k = 0; k < 9; k++) begin
            if (k == 4) repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b1, k < 8 ? 1'((8'h3C >> k) & 8'h01) : 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        // abort after 4 bits (abort together with en), then 0x55
        send_bits(9'h1FF, 4);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(9'h055, 9);
        // back-to-back frames with no gap
        send_bits(9'h0C3, 8);
        send_bits(9'h13C, 9);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        // reset mid-frame
        send_bits(9'h1FF, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        send_bits(9'h0A5, 9);
        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                  (r >= 1 && r < 5) ? 1'b1 : 1'b0, (r < 1) ? 1'b1 : 1'b0);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        done = 1'b1;
    end

endmodule
